// File: rtl/vector_regfile_stream.sv
// vector_regfile_stream: vector register file with masked vector write, element-serial fill port and busy scoreboard; define VRF_BYPASS_EN for same-cycle write-through reads
module vector_regfile_stream #(
    parameter int VREGS = 8,
    parameter int VLEN = 8,
    parameter int EWIDTH = 32,
    localparam int RW = $clog2(VREGS),
    localparam int CW = $clog2(VLEN + 1),
    localparam int EW = $clog2(VLEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RW-1:0]          rs1,
    input  logic [RW-1:0]          rs2,
    output logic [EWIDTH*VLEN-1:0] rs1_data,
    output logic [EWIDTH*VLEN-1:0] rs2_data,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    input  logic                   we,
    input  logic [RW-1:0]          rd,
    input  logic [VLEN-1:0]        vmask,
    input  logic [EWIDTH*VLEN-1:0] rd_data,
    output logic                   wr_err,
    input  logic                   ld_start,
    input  logic [RW-1:0]          ld_vd,
    input  logic [CW-1:0]          ld_vl,
    input  logic                   ld_valid,
    input  logic [EWIDTH-1:0]      ld_elem,
    output logic                   ld_ready,
    output logic                   ld_busy,
    output logic                   ld_done
);
    typedef enum logic {IDLE, FILL} state_t;
    state_t state;
    logic [VLEN-1:0][EWIDTH-1:0] vreg [VREGS];
    logic [VREGS-1:0] busy;
    logic [RW-1:0] vd;
    logic [CW-1:0] cnt, vl, eff_vl;
    logic wr_ok;
    assign eff_vl = (ld_vl > CW'(VLEN)) ? CW'(VLEN) : ld_vl;
    assign wr_ok = we && !busy[rd];
    assign ld_ready = state == FILL;
    assign ld_busy = state == FILL;
    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];
`ifdef VRF_BYPASS_EN
    always_comb begin
        rs1_data = vreg[rs1];
        rs2_data = vreg[rs2];
        for (int j = 0; j < VLEN; j++) begin
            if (wr_ok && vmask[j] && rs1 == rd) rs1_data[j*EWIDTH +: EWIDTH] = rd_data[j*EWIDTH +: EWIDTH];
            if (wr_ok && vmask[j] && rs2 == rd) rs2_data[j*EWIDTH +: EWIDTH] = rd_data[j*EWIDTH +: EWIDTH];
        end
    end
`else
    assign rs1_data = vreg[rs1];
    assign rs2_data = vreg[rs2];
`endif
    // a vector write and a fill element never target the same register: busy blocks the former
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VREGS; i++) vreg[i] <= '0;
            busy <= '0;
            state <= IDLE;
            cnt <= '0;
            vl <= '0;
            vd <= '0;
            wr_err <= 1'b0;
            ld_done <= 1'b0;
        end else begin
            wr_err <= we && busy[rd];
            ld_done <= 1'b0;
            for (int j = 0; j < VLEN; j++)
                if (wr_ok && vmask[j]) vreg[rd][j] <= rd_data[j*EWIDTH +: EWIDTH];
            if (state == IDLE) begin
                if (ld_start && eff_vl == '0) ld_done <= 1'b1;
                else if (ld_start) begin
                    vd <= ld_vd;
                    vl <= eff_vl;
                    cnt <= '0;
                    busy[ld_vd] <= 1'b1;
                    state <= FILL;
                end
            end else if (ld_valid) begin
                vreg[vd][cnt[EW-1:0]] <= ld_elem;
                cnt <= cnt + CW'(1);
                if (cnt == vl - CW'(1)) begin
                    busy[vd] <= 1'b0;
                    state <= IDLE;
                    ld_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vector_regfile_stream.sv
// tb_vector_regfile_stream: directed and random stimulus checked every cycle against an array/scoreboard model
module tb_vector_regfile_stream;
    logic clk, rst;
    logic [2:0] rs1, rs2, rd, ld_vd;
    logic [255:0] rs1_data, rs2_data, rd_data;
    logic rs1_busy, rs2_busy, we, wr_err, ld_start, ld_valid, ld_ready, ld_busy, ld_done;
    logic [7:0] vmask;
    logic [3:0] ld_vl;
    logic [31:0] ld_elem;
    int checks = 0, failures = 0;
    logic [31:0] mv [8][8];
    logic [7:0] mb;
    bit mfill, mdone, mwerr;
    int fvd, fidx, flen;

    vector_regfile_stream #(.VREGS(8), .VLEN(8), .EWIDTH(32)) dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .we(we), .rd(rd), .vmask(vmask), .rd_data(rd_data),
        .wr_err(wr_err), .ld_start(ld_start), .ld_vd(ld_vd), .ld_vl(ld_vl), .ld_valid(ld_valid),
        .ld_elem(ld_elem), .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] splat(input logic [31:0] v);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [255:0] mread(input logic [2:0] r);
        logic [255:0] val;
        for (int j = 0; j < 8; j++) begin
            val[j*32 +: 32] = mv[r][j];
`ifdef VRF_BYPASS_EN
            if (we && !mb[rd] && r == rd && vmask[j]) val[j*32 +: 32] = rd_data[j*32 +: 32];
`endif
        end
        return val;
    endfunction

    task automatic compare();
        chk("rs1_data", rs1_data, mread(rs1));
        chk("rs2_data", rs2_data, mread(rs2));
        chk("rs1_busy", 256'(rs1_busy), 256'(mb[rs1]));
        chk("rs2_busy", 256'(rs2_busy), 256'(mb[rs2]));
        chk("wr_err", 256'(wr_err), 256'(mwerr));
        chk("ld_ready", 256'(ld_ready), 256'(mfill));
        chk("ld_busy", 256'(ld_busy), 256'(mfill));
        chk("ld_done", 256'(ld_done), 256'(mdone));
    endtask

    task automatic model_update();
        bit nd;
        int eff;
        nd = 0;
        if (rst) begin
            for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) mv[i][j] = '0;
            mb = '0; mfill = 0; fidx = 0; mdone = 0; mwerr = 0;
        end else begin
            mwerr = we && mb[rd];
            if (we && !mb[rd]) for (int j = 0; j < 8; j++) if (vmask[j]) mv[rd][j] = rd_data[j*32 +: 32];
            if (!mfill) begin
                if (ld_start) begin
                    eff = ld_vl > 8 ? 8 : int'(ld_vl);
                    if (eff == 0) nd = 1;
                    else begin
                        mfill = 1; fvd = int'(ld_vd); flen = eff; fidx = 0; mb[ld_vd] = 1'b1;
                    end
                end
            end else if (ld_valid) begin
                mv[fvd][fidx] = ld_elem;
                fidx++;
                if (fidx == flen) begin
                    mfill = 0; mb[fvd] = 1'b0; nd = 1;
                end
            end
            mdone = nd;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; rs1 = 0; rs2 = 0; rd = 0; we = 0; vmask = 0; rd_data = 0;
        ld_start = 0; ld_vd = 0; ld_vl = 0; ld_valid = 0; ld_elem = 0;
        model_update();
        @(posedge clk); #1;
        step();
        rst = 0;
        // reset clears a written register
        we = 1; rd = 3; vmask = 8'hFF; rd_data = splat(32'hFFFF_FFFF);
        step();
        we = 0; rs1 = 3; rs2 = 3; #1;
        chk("lit_v3_ones", rs1_data, splat(32'hFFFF_FFFF));
        rst = 1;
        step();
        rst = 0; #1;
        chk("lit_rst_rs1", rs1_data, '0);
        chk("lit_rst_rs2", rs2_data, '0);
        chk("lit_rst_done", 256'(ld_done), 0);
        chk("lit_rst_busy", 256'(rs1_busy), 0);
        // masked write
        we = 1; rd = 2; vmask = 8'b1010_0101;
        for (int j = 0; j < 8; j++) rd_data[j*32 +: 32] = 32'hA0 + j;
        step();
        we = 0; rs1 = 2; #1;
        chk("lit_masked", rs1_data, {32'hA7, 32'h0, 32'hA5, 32'h0, 32'h0, 32'hA2, 32'h0, 32'hA0});
        // fill with gap and conflicting write
        we = 1; rd = 5; vmask = 8'hFF; rd_data = splat(32'hEE);
        step();
        we = 0; ld_start = 1; ld_vd = 5; ld_vl = 3; rs1 = 5;
        step();
        ld_start = 0; #1;
        chk("lit_fill_busy", 256'(rs1_busy), 1);
        chk("lit_fill_ready", 256'(ld_ready), 1);
        ld_valid = 1; ld_elem = 32'h11;
        step();
        ld_valid = 0; we = 1; rd = 5; rd_data = splat(32'h77);
        step();
        chk("lit_wr_err", 256'(wr_err), 1);
        rd = 4;
        step();
        we = 0;
        chk("lit_wr_err_clr", 256'(wr_err), 0);
        ld_valid = 1; ld_elem = 32'h22;
        step();
        ld_elem = 32'h33;
        step();
        ld_valid = 0; rs2 = 4; #1;
        chk("lit_fill_done", 256'(ld_done), 1);
        chk("lit_fill_unbusy", 256'(rs1_busy), 0);
        chk("lit_v4", rs2_data, splat(32'h77));
        chk("lit_v5", rs1_data, {32'hEE, 32'hEE, 32'hEE, 32'hEE, 32'hEE, 32'h33, 32'h22, 32'h11});
        step();
        // oversize length, back-to-back fill, zero length, reset mid-fill
        ld_start = 1; ld_vd = 7; ld_vl = 15;
        step();
        ld_start = 0; ld_valid = 1;
        for (int k = 0; k < 8; k++) begin
            ld_elem = $urandom;
            step();
        end
        ld_valid = 0; #1;
        chk("lit_vl15_done", 256'(ld_done), 1);
        ld_start = 1; ld_vd = 2; ld_vl = 2;
        step();
        ld_start = 0; #1;
        chk("lit_b2b_busy", 256'(ld_busy), 1);
        ld_valid = 1;
        for (int k = 0; k < 2; k++) begin
            ld_elem = $urandom;
            step();
        end
        ld_valid = 0; ld_start = 1; ld_vd = 6; ld_vl = 0; rs1 = 6;
        step();
        ld_start = 0; #1;
        chk("lit_vl0_done", 256'(ld_done), 1);
        chk("lit_vl0_busy", 256'(rs1_busy), 0);
        chk("lit_vl0_fsm", 256'(ld_busy), 0);
        ld_start = 1; ld_vd = 0; ld_vl = 4;
        step();
        ld_start = 0; ld_valid = 1;
        for (int k = 0; k < 2; k++) begin
            ld_elem = $urandom;
            step();
        end
        ld_valid = 0; rst = 1;
        step();
        rst = 0; #1;
        chk("lit_abort_busy", 256'(ld_busy), 0);
        chk("lit_abort_done", 256'(ld_done), 0);
        step();
        chk("lit_abort_done2", 256'(ld_done), 0);
        // write-through on read port 1
        we = 1; rd = 1; rs1 = 1; vmask = 8'h0F;
        for (int j = 0; j < 8; j++) rd_data[j*32 +: 32] = 32'hB0 + j;
        #1;
`ifdef VRF_BYPASS_EN
        chk("lit_bypass", rs1_data, {32'h0, 32'h0, 32'h0, 32'h0, 32'hB3, 32'hB2, 32'hB1, 32'hB0});
`else
        chk("lit_nobypass", rs1_data, '0);
`endif
        step();
        we = 0; #1;
        chk("lit_after_wr", rs1_data, {32'h0, 32'h0, 32'h0, 32'h0, 32'hB3, 32'hB2, 32'hB1, 32'hB0});
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            rs1 = 3'($urandom); rs2 = 3'($urandom); rd = 3'($urandom);
            we = $urandom_range(0, 1) == 1;
            vmask = 8'($urandom);
            for (int j = 0; j < 8; j++) rd_data[j*32 +: 32] = $urandom;
            ld_start = $urandom_range(0, 3) == 0;
            ld_vd = 3'($urandom); ld_vl = 4'($urandom_range(0, 15));
            ld_valid = $urandom_range(0, 2) != 0;
            ld_elem = $urandom;
            step();
        end
        rst = 0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
